// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle for mem_access_unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface mem_access_unit_if #(
  parameter int OFS_W = 8
);
  logic             req_valid;
  logic             req_we;
  logic [15:0]      req_base;
  logic [OFS_W-1:0] req_ofs;
  logic [15:0]      req_wdata;
  logic             req_ready;
  logic             resp_valid;
  logic [15:0]      resp_data;
  logic             mem_read;
  logic             mem_write;
  logic [7:0]       mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_base, req_ofs, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_base, req_ofs, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Four-cycle load/store sequencer: base+signed offset addressing onto a data memory.
// Optional per-type access counters are built only when ACCESS_CNT_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request, strobes low
// CALC   | effective address computed, registered on exit
// ACCESS | single-cycle mem_read or mem_write strobe
// DONE   | resp_valid pulse, then back to IDLE
module mem_access_unit #(
  parameter int OFS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus,
  input  logic               cnt_clr,
  output logic [15:0]        ld_count,
  output logic [15:0]        st_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             we_q;
  logic [7:0]       base_q;
  logic [OFS_W-1:0] ofs_q;
  logic [15:0]      wdata_q;
  logic [7:0]       addr_q;
  logic [15:0]      mem_wdata_q;
  logic [15:0]      resp_data_q;

  logic [7:0]       ofs8;
  logic [7:0]       eff_addr;
  logic             accept;
  logic             ready;
  logic             rd_strobe;
  logic             wr_strobe;
  logic             rsp_pulse;

  // Only the low byte of the base register addresses the 256-word memory.
  logic unused_base_hi;
  assign unused_base_hi = ^bus.req_base[15:8];

  // Bring the offset to 8 bits; addition is mod 256 so truncation is exact.
  if (OFS_W >= 8) begin : g_ofs_trunc
    assign ofs8 = ofs_q[7:0];
    if (OFS_W > 8) begin : g_ofs_hi
      logic unused_ofs_hi;
      assign unused_ofs_hi = ^ofs_q[OFS_W-1:8];
    end
  end else begin : g_ofs_sext
    assign ofs8 = {{(8-OFS_W){ofs_q[OFS_W-1]}}, ofs_q};
  end

  assign eff_addr = base_q + ofs8;
  assign accept   = ready & bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    rsp_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        rd_strobe = ~we_q;
        wr_strobe = we_q;
        state_nxt = DONE;
      end
      DONE: begin
        rsp_pulse = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      base_q      <= 8'h00;
      ofs_q       <= '0;
      wdata_q     <= 16'h0000;
      addr_q      <= 8'h00;
      mem_wdata_q <= 16'h0000;
      resp_data_q <= 16'h0000;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        base_q  <= bus.req_base[7:0];
        ofs_q   <= bus.req_ofs;
        wdata_q <= bus.req_wdata;
      end
      if (state == CALC) begin
        addr_q <= eff_addr;
        if (we_q) begin
          mem_wdata_q <= wdata_q;
        end
      end
      if ((state == ACCESS) && !we_q) begin
        resp_data_q <= bus.mem_rdata;
      end
    end
  end

  // Strobes are decoded from state, so an async reset in ACCESS kills the write at once.
  assign bus.req_ready  = ready;
  assign bus.mem_read   = rd_strobe;
  assign bus.mem_write  = wr_strobe;
  assign bus.resp_valid = rsp_pulse;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_data  = resp_data_q;

`ifdef ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_count <= 16'h0000;
      st_count <= 16'h0000;
    end else if (cnt_clr) begin
      ld_count <= 16'h0000;
      st_count <= 16'h0000;
    end else if (state == ACCESS) begin
      if (we_q) begin
        st_count <= st_count + 16'd1;
      end else begin
        ld_count <= ld_count + 16'd1;
      end
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ld_count       = 16'h0000;
  assign st_count       = 16'h0000;
`endif

endmodule
